key_scanner: RTL

//  Parametrised debounced key front-end for N_KEYS push-buttons. Each key gets a
//  2-FF synchroniser, a millisecond debounce filter and an optional auto-repeat.

---
 rtl/key_scanner.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/key_scanner.sv
// Debounced key front-end: per-key 2-FF synchroniser, millisecond debounce filter,
// auto-repeat FSM and a priority-encoded single-entry key_code slot (valid/ack).
module key_scanner #(
  parameter int N_KEYS          = 3,
  parameter int CODE_W          = 2,
  parameter int DEBOUNCE_MS     = 10,
  parameter int REPEAT_DELAY_MS = 400,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              one_ms_tick,
  input  logic [N_KEYS-1:0] btn,
  input  logic              repeat_en,
  input  logic              key_ack,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  output logic [N_KEYS-1:0] key_held,
  output logic              overrun
);
  localparam int MAX_A  = (DEBOUNCE_MS > REPEAT_DELAY_MS) ? DEBOUNCE_MS : REPEAT_DELAY_MS;
  localparam int MAX_MS = (MAX_A > REPEAT_RATE_MS) ? MAX_A : REPEAT_RATE_MS;
  localparam int CNT_W  = $clog2(MAX_MS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] DB_LIM   = CNT_W'(DEBOUNCE_MS);
  localparam logic [CNT_W-1:0] DLY_LIM  = CNT_W'(REPEAT_DELAY_MS);
  localparam logic [CNT_W-1:0] RATE_LIM = CNT_W'(REPEAT_RATE_MS);

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_DELAY    = 2'd1,
    ST_REPEAT   = 2'd2
  } key_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic [N_KEYS-1:0] sync1_q, sync2_q, stable_q, stable_d;
  logic [CNT_W-1:0]  db_cnt_q [N_KEYS];
  logic [CNT_W-1:0]  db_cnt_d [N_KEYS];
  logic [CNT_W-1:0]  rep_cnt_q [N_KEYS];
  logic [CNT_W-1:0]  rep_cnt_d [N_KEYS];
  logic [CNT_W-1:0]  rep_inc_s [N_KEYS];
  key_state_e        state_q [N_KEYS];
  key_state_e        state_d [N_KEYS];
  logic [N_KEYS-1:0] ev_s;
  logic [CODE_W-1:0] win_code_s;
  logic              any_ev_s, multi_ev_s;
  logic              key_valid_q, key_valid_d, overrun_q, overrun_d;
  logic [CODE_W-1:0] key_code_q, key_code_d;

  // Debounce filter: a differing synced level must persist for DEBOUNCE_MS ticks
  always_comb begin
    stable_d = stable_q;
    for (int k = 0; k < N_KEYS; k++) begin
      db_cnt_d[k] = db_cnt_q[k];
      if (!one_ms_tick) begin
        db_cnt_d[k] = db_cnt_q[k];
      end else if (sync2_q[k] == stable_q[k]) begin
        db_cnt_d[k] = '0;
      end else if (sat_inc(db_cnt_q[k]) >= DB_LIM) begin
        stable_d[k] = sync2_q[k];
        db_cnt_d[k] = '0;
      end else begin
        db_cnt_d[k] = sat_inc(db_cnt_q[k]);
      end
    end
  end

  // Synchroniser, debounce state and per-key FSM state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      for (int k = 0; k < N_KEYS; k++) begin
        db_cnt_q[k]  <= '0;
        rep_cnt_q[k] <= '0;
        state_q[k]   <= ST_RELEASED;
      end
    end else begin
      sync1_q  <= btn;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      for (int k = 0; k < N_KEYS; k++) begin
        db_cnt_q[k]  <= db_cnt_d[k];
        rep_cnt_q[k] <= rep_cnt_d[k];
        state_q[k]   <= state_d[k];
      end
    end
  end

  // Per-key next state; a repeat_en drop parks the key in DELAY with a saturated counter
  always_comb begin
    for (int k = 0; k < N_KEYS; k++) begin
      rep_inc_s[k] = sat_inc(rep_cnt_q[k]);
      state_d[k]   = state_q[k];
      rep_cnt_d[k] = rep_cnt_q[k];
      case (state_q[k])
        ST_RELEASED: begin
          if (stable_q[k]) begin
            state_d[k]   = ST_DELAY;
            rep_cnt_d[k] = '0;
          end else begin
            rep_cnt_d[k] = '0;
          end
        end
        ST_DELAY: begin
          if (!stable_q[k]) begin
            state_d[k]   = ST_RELEASED;
            rep_cnt_d[k] = '0;
          end else if (!one_ms_tick) begin
            rep_cnt_d[k] = rep_cnt_q[k];
          end else if (repeat_en && (rep_inc_s[k] == DLY_LIM)) begin
            state_d[k]   = ST_REPEAT;
            rep_cnt_d[k] = '0;
          end else begin
            rep_cnt_d[k] = rep_inc_s[k];
          end
        end
        ST_REPEAT: begin
          if (!stable_q[k]) begin
            state_d[k]   = ST_RELEASED;
            rep_cnt_d[k] = '0;
          end else if (!repeat_en) begin
            state_d[k]   = ST_DELAY;
            rep_cnt_d[k] = CNT_MAX;
          end else if (!one_ms_tick) begin
            rep_cnt_d[k] = rep_cnt_q[k];
          end else begin
            rep_cnt_d[k] = (rep_inc_s[k] == RATE_LIM) ? '0 : rep_inc_s[k];
          end
        end
        default: begin
          state_d[k]   = ST_RELEASED;
          rep_cnt_d[k] = '0;
        end
      endcase
    end
  end

  // Per-key event outputs of the FSM
  always_comb begin
    ev_s = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      case (state_q[k])
        ST_RELEASED: ev_s[k] = stable_q[k];
        ST_DELAY:    ev_s[k] = stable_q[k] && one_ms_tick && repeat_en && (rep_inc_s[k] == DLY_LIM);
        ST_REPEAT:   ev_s[k] = stable_q[k] && one_ms_tick && repeat_en && (rep_inc_s[k] == RATE_LIM);
        default:     ev_s[k] = 1'b0;
      endcase
    end
  end

  // Lowest index wins; any extra simultaneous event or a busy slot is an overrun
  always_comb begin
    win_code_s = '0;
    for (int k = N_KEYS - 1; k >= 0; k--) begin
      win_code_s = ev_s[k] ? CODE_W'(k + 1) : win_code_s;
    end
    any_ev_s    = |ev_s;
    multi_ev_s  = |(ev_s & (ev_s - N_KEYS'(1)));
    key_valid_d = key_valid_q;
    key_code_d  = key_code_q;
    overrun_d   = multi_ev_s || (any_ev_s && key_valid_q && !key_ack);
    if (any_ev_s && (!key_valid_q || key_ack)) begin
      key_valid_d = 1'b1;
      key_code_d  = win_code_s;
    end else if (key_ack && !any_ev_s) begin
      key_valid_d = 1'b0;
      key_code_d  = '0;
    end else begin
      key_valid_d = key_valid_q;
      key_code_d  = key_code_q;
    end
  end

  // Output slot registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      overrun_q   <= overrun_d;
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_held  = stable_q;
  assign overrun   = overrun_q;
endmodule
